// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic PE array: skews an N-lane operand vector so lane i lags by i
// cycles, zero-fills empty slots and tags the last beat of each stream with a done pulse.
module systolic_skew_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    output logic [N*DW-1:0] lane_out,
    output logic [N-1:0]    lane_valid,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   beat_count
);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e        state_q;
    logic [CW-1:0] beat_count_q;
    logic [N-1:0]  tag_q;
    logic          accept;

    assign in_ready = (state_q != StDrain) && !abort;
    assign accept   = in_valid && in_ready;

    // Lane i is a chain of i+1 registers; bubbles enter as zero data so invalid slots read 0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] data_q [i+1];
        logic          vld_q  [i+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= i; s++) begin
                    data_q[s] <= '0;
                    vld_q[s]  <= 1'b0;
                end
            end else if (abort) begin
                for (int s = 0; s <= i; s++) begin
                    data_q[s] <= '0;
                    vld_q[s]  <= 1'b0;
                end
            end else begin
                data_q[0] <= accept ? in_data[i*DW +: DW] : '0;
                vld_q[0]  <= accept;
                for (int s = 1; s <= i; s++) begin
                    data_q[s] <= data_q[s-1];
                    vld_q[s]  <= vld_q[s-1];
                end
            end
        end

        assign lane_out[i*DW +: DW] = data_q[i];
        assign lane_valid[i]        = vld_q[i];
    end

    // Last-beat tag rides alongside lane N-1, so it emerges with that lane's final element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (abort) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= accept && in_last;
            for (int s = 1; s < int'(N); s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign done = tag_q[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            beat_count_q <= '0;
        end else if (abort) begin
            state_q <= StIdle;
        end else begin
            if (accept) begin
                if (state_q == StIdle) begin
                    beat_count_q <= CW'(1);
                end else if (beat_count_q != '1) begin
                    beat_count_q <= beat_count_q + CW'(1);
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= in_last ? StDrain : StStream;
                    end
                end
                StStream: begin
                    if (accept && in_last) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy       = (state_q != StIdle);
    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=4, DW=8): streams, bubbles, drain backpressure,
// abort and asynchronous reset, with hand-computed lane images.
module tb_systolic_skew_feeder;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] lane_out;
    logic [3:0]  lane_valid;
    logic        busy;
    logic        done;
    logic [15:0] beat_count;

    int n_assert = 0;
    int n_fail   = 0;

    systolic_skew_feeder #(.N(4), .DW(8), .CW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .lane_out   (lane_out),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] data, input logic [3:0] vld,
                           input logic dn);
        chk({tag, "_data"}, lane_out, data);
        chk({tag, "_vld"}, {28'd0, lane_valid}, {28'd0, vld});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, dn});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_last  = 1'b0;
    endtask

    task automatic run_basic(input string p);
        send(32'h04030201, 1'b0); step(); chk_out({p, "_c1"}, 32'h00000001, 4'b0001, 1'b0);
        chk({p, "_rdy1"}, {31'd0, in_ready}, 32'd1);
        send(32'h08070605, 1'b0); step(); chk_out({p, "_c2"}, 32'h00000205, 4'b0011, 1'b0);
        send(32'h0C0B0A09, 1'b0); step(); chk_out({p, "_c3"}, 32'h00030609, 4'b0111, 1'b0);
        send(32'h100F0E0D, 1'b1); step(); chk_out({p, "_c4"}, 32'h04070A0D, 4'b1111, 1'b0);
        chk({p, "_rdy4"}, {31'd0, in_ready}, 32'd0);
        chk({p, "_cnt4"}, {16'd0, beat_count}, 32'd4);
        idle_in();
        step(); chk_out({p, "_c5"}, 32'h080B0E00, 4'b1110, 1'b0);
        step(); chk_out({p, "_c6"}, 32'h0C0F0000, 4'b1100, 1'b0);
        step(); chk_out({p, "_c7"}, 32'h10000000, 4'b1000, 1'b1);
        chk({p, "_busy7"}, {31'd0, busy}, 32'd1);
        step(); chk_out({p, "_c8"}, 32'h00000000, 4'b0000, 1'b0);
        chk({p, "_busy8"}, {31'd0, busy}, 32'd0);
        chk({p, "_rdy8"}, {31'd0, in_ready}, 32'd1);
        chk({p, "_cnt8"}, {16'd0, beat_count}, 32'd4);
    endtask

    initial begin
        rst_n = 1'b0;
        abort = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk_out("rst", 32'h0, 4'b0000, 1'b0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, beat_count}, 32'd0);
        rst_n = 1'b1;
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);

        // Back-to-back four-beat stream
        run_basic("s1");

        // Bubble between beats 2 and 3
        send(32'h04030201, 1'b0); step(); chk_out("b_c1", 32'h00000001, 4'b0001, 1'b0);
        chk("b_cnt1", {16'd0, beat_count}, 32'd1);
        send(32'h08070605, 1'b0); step(); chk_out("b_c2", 32'h00000205, 4'b0011, 1'b0);
        idle_in();                step(); chk_out("b_c3", 32'h00030600, 4'b0110, 1'b0);
        chk("b_busy3", {31'd0, busy}, 32'd1);
        send(32'h0C0B0A09, 1'b0); step(); chk_out("b_c4", 32'h04070009, 4'b1101, 1'b0);
        send(32'h100F0E0D, 1'b1); step(); chk_out("b_c5", 32'h08000A0D, 4'b1011, 1'b0);
        idle_in();
        step(); chk_out("b_c6", 32'h000B0E00, 4'b0110, 1'b0);
        step(); chk_out("b_c7", 32'h0C0F0000, 4'b1100, 1'b0);
        step(); chk_out("b_c8", 32'h10000000, 4'b1000, 1'b1);
        step(); chk_out("b_c9", 32'h00000000, 4'b0000, 1'b0);
        chk("b_cnt9", {16'd0, beat_count}, 32'd4);

        // Single-beat stream, then in_valid held high through the drain
        send(32'hAABBCCDD, 1'b1); step(); chk_out("sb_c1", 32'h000000DD, 4'b0001, 1'b0);
        chk("sb_rdy1", {31'd0, in_ready}, 32'd0);
        send(32'h44332211, 1'b0);
        step(); chk_out("sb_c2", 32'h0000CC00, 4'b0010, 1'b0);
        chk("sb_cnt2", {16'd0, beat_count}, 32'd1);
        step(); chk_out("sb_c3", 32'h00BB0000, 4'b0100, 1'b0);
        step(); chk_out("sb_c4", 32'hAA000000, 4'b1000, 1'b1);
        chk("sb_rdy4", {31'd0, in_ready}, 32'd0);
        chk("sb_cnt4", {16'd0, beat_count}, 32'd1);
        step(); chk_out("sb_c5", 32'h00000000, 4'b0000, 1'b0);
        chk("sb_busy5", {31'd0, busy}, 32'd0);
        chk("sb_rdy5", {31'd0, in_ready}, 32'd1);
        chk("sb_cnt5", {16'd0, beat_count}, 32'd1);
        // Held beat is taken only now, as the first beat of a new stream
        step(); chk_out("bp_c1", 32'h00000011, 4'b0001, 1'b0);
        chk("bp_cnt1", {16'd0, beat_count}, 32'd1);
        send(32'h88776655, 1'b0);
        step(); chk_out("bp_c2", 32'h00002255, 4'b0011, 1'b0);
        chk("bp_cnt2", {16'd0, beat_count}, 32'd2);

        // Abort with a beat still presented
        send(32'hCCBBAA99, 1'b1);
        abort = 1'b1;
        #1;
        chk("ab_rdy", {31'd0, in_ready}, 32'd0);
        step();
        abort = 1'b0;
        idle_in();
        chk_out("ab_c1", 32'h0, 4'b0000, 1'b0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_cnt", {16'd0, beat_count}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("ab_tail%0d", k), 32'h0, 4'b0000, 1'b0);
        end

        // Asynchronous reset in the middle of a drain
        send(32'h04030201, 1'b1); step();
        idle_in();
        step(); chk_out("rd_c2", 32'h00000200, 4'b0010, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("rd_async", 32'h0, 4'b0000, 1'b0);
        chk("rd_busy", {31'd0, busy}, 32'd0);
        chk("rd_cnt", {16'd0, beat_count}, 32'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("rd_tail%0d", k), 32'h0, 4'b0000, 1'b0);
        end
        run_basic("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Edge feeder for the systolic PE array. It accepts one N-element operand vector per beat on a valid/ready stream and drives the N lanes on one edge of the array (the a_in row edge or the b_in column edge).
- Lane i is delayed by i cycles, which gives the diagonal wavefront the PE grid needs.
- Holes between beats, and the tail of each stream, are filled with zeros so that the PE accumulations downstream are not disturbed.
- A tag travels down the chain with the last beat and signals stream completion.

Parameters:
- N, 4, number of lanes (array edge length), N >= 1
- DW, 8, operand width per lane; matches the PE operand width
- CW, 16, width of the beat counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous flush; highest priority after reset
- in_valid  in  1  input beat valid
- in_ready  out  1  feeder can accept a beat
- in_data  in  N*DW  operand vector; lane i = in_data[i*DW +: DW]
- in_last  in  1  marks the final beat of a stream
- lane_out  out  N*DW  skewed operands to the array edge; lane i = lane_out[i*DW +: DW]
- lane_valid  out  N  per-lane data-valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: the last beat's element is on lane N-1 this cycle
- beat_count  out  CW  beats accepted in the current/most recent stream

Behaviour:
- Interface decision: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: all lane registers, lane_valid, the tag chain, done and beat_count clear to 0; state = IDLE; busy = 0; in_ready = 1 once rst_n deasserts.
- Accept condition: a beat is accepted at a rising edge when in_valid & in_ready.
- in_ready is combinational: 1 in IDLE and STREAM, 0 in DRAIN, forced 0 while abort = 1.
- Skew pipeline: lane i is a chain of i+1 registers.
  - A beat accepted at edge k appears on lane i after edge k+i, i.e. lane 0 presents it in the cycle after acceptance.
  - Lane 0 loads in_data lane 0 with lane_valid[0] = 1 on accept. Otherwise it loads 0 with lane_valid[0] = 0 (bubble).
  - Deeper stages shift unconditionally every cycle. There is no output backpressure; the array is free-running.
- Zero fill: lane_out is 0 whenever the matching lane_valid bit is 0. Data in invalid slots is never X or stale.
- Last tag:
  - A 1-bit tag enters with an accepted beat when in_last = 1.
  - It shifts along the lane N-1 chain, so it takes N registers.
  - done = tag at the lane N-1 output, which is a registered output.
- State machine (IDLE, STREAM, DRAIN):
  - IDLE -> STREAM on an accepted beat with in_last = 0.
  - IDLE -> DRAIN on an accepted beat with in_last = 1 (single-beat stream).
  - STREAM -> DRAIN on an accepted beat with in_last = 1.
  - STREAM stays in STREAM on bubbles.
  - DRAIN -> IDLE at the edge where done = 1.
  - For N = 1, DRAIN lasts exactly one cycle.
- Drain length: the last beat accepted at edge L gives done = 1 in the cycle after edge L+N-1. in_ready is 0 from edge L until the FSM returns to IDLE.
- beat_count:
  - Loads 1 on the first accept from IDLE.
  - Increments on each further accept and saturates at 2^CW-1.
  - Holds its value after the stream ends until the next stream's first accept.
- abort (synchronous, when rst_n = 1): at the edge it clears all lane registers, lane_valid, the tag chain and done, and sets state = IDLE. beat_count is held. Any beat presented in the abort cycle is not accepted.
- Reset mid-stream: everything clears immediately, asynchronously; no done pulse is generated.
- Simultaneous events:
  - An accept and a tag exit in the same cycle are independent.
  - An accept in IDLE in the same cycle that DRAIN -> IDLE occurs cannot happen, because in_ready = 0 in DRAIN.

Test Plan:
- Reset then N = 4, DW = 8: stream 4 beats {lanes 3..0} = 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D with in_last on beat 4, back-to-back. Required response:
  - Lane 0 shows 01,05,09,0D in cycles 1-4.
  - Lane 3 shows 04,08,0C,10 in cycles 4-7, with zeros and lane_valid = 0 elsewhere.
  - done in cycle 7; beat_count = 4; busy falls after cycle 7.
- Bubble: in_valid low for one cycle between beats 2 and 3. Required response: each lane shows exactly one zero slot (lane_valid = 0) between its elements 2 and 3, offset by i cycles per lane; done shifts one cycle later.
- Single-beat stream 0xAABBCCDD with in_last = 1 from IDLE. Required response:
  - in_ready drops for the cycles of the drain.
  - Lane 3 shows AA in cycle 4 together with done = 1.
  - The FSM returns to IDLE, after which in_ready = 1 and beat_count = 1.
- Backpressure: hold in_valid = 1 during DRAIN. Required response: no accept (beat_count unchanged) until IDLE; the next stream starts with beat_count = 1.
- abort in the cycle after beat 2 of a 4-beat stream. Required response: all lane_out/lane_valid = 0 next cycle, no done pulse, busy = 0, beat_count stays at 2.
- Async rst_n pulse mid-drain (between clock edges). Required response: outputs are 0 immediately and no done pulse appears; a new stream afterwards behaves as in scenario 1.
